// File: rtl/primitive_graph_node_lp_pkg.sv
// Shared widths and types for Forge graph vertex cells and the fabric that connects them.
package graph_forge_pkg;

  localparam int GF_NODE_ID_WIDTH = 8;
  localparam int GF_WEIGHT_WIDTH  = 16;
  localparam int GF_MAX_DEGREE    = 16;
  localparam int GF_PART_WIDTH    = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SCAN_REQ  = 3'd1,
    ST_SCAN_WAIT = 3'd2,
    ST_ARGMAX    = 3'd3,
    ST_UPDATE    = 3'd4
  } state_e;

  typedef struct packed {
    logic [GF_NODE_ID_WIDTH-1:0] nbr;
    logic [GF_WEIGHT_WIDTH-1:0]  weight;
  } edge_t;

endpackage

// File: rtl/primitive_graph_edge_ram.sv
// Edge table storage: one write port, one asynchronous read port.
module primitive_graph_edge_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: storage arrays get no reset; the contents are only meaningful once written,
  // and a reset on every entry would turn a compact RAM into a wall of flops.
  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/primitive_graph_node_lp.sv
// Graph vertex cell: queries every neighbour's partition, scores partitions by edge weight,
// and moves the vertex to the heaviest one (ties favour the current partition, then lowest index).
module primitive_graph_node_lp
  import graph_forge_pkg::*;
#(
  parameter int  NODE_ID_WIDTH = GF_NODE_ID_WIDTH,
  parameter int  WEIGHT_WIDTH  = GF_WEIGHT_WIDTH,
  parameter int  MAX_DEGREE    = GF_MAX_DEGREE,
  parameter int  PART_WIDTH    = GF_PART_WIDTH,
  localparam int DEG_W         = $clog2(MAX_DEGREE),
  localparam int NUM_PARTS     = 2 ** PART_WIDTH,
  localparam int ACC_WIDTH     = WEIGHT_WIDTH + $clog2(MAX_DEGREE + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     node_enable,
  input  logic                     edge_wr_en,
  input  logic [DEG_W-1:0]         edge_wr_idx,
  input  logic [NODE_ID_WIDTH-1:0] edge_wr_nbr,
  input  logic [WEIGHT_WIDTH-1:0]  edge_wr_weight,
  input  logic                     degree_wr,
  input  logic [DEG_W:0]           degree_in,
  input  logic                     part_init,
  input  logic [PART_WIDTH-1:0]    part_init_val,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     changed,
  output logic                     nbr_req_valid,
  input  logic                     nbr_req_ready,
  output logic [NODE_ID_WIDTH-1:0] nbr_req_id,
  input  logic                     nbr_rsp_valid,
  input  logic [PART_WIDTH-1:0]    nbr_rsp_part,
  output logic [PART_WIDTH-1:0]    current_partition,
  output logic [ACC_WIDTH-1:0]     total_weight,
  output logic [DEG_W:0]           node_degree
);

  localparam logic [DEG_W:0]        DEG_ONE  = (DEG_W + 1)'(1);
  localparam logic [DEG_W:0]        DEG_MAX  = (DEG_W + 1)'(MAX_DEGREE);
  localparam logic [PART_WIDTH-1:0] PART_ONE = PART_WIDTH'(1);
  localparam logic [PART_WIDTH-1:0] PART_TOP = PART_WIDTH'(NUM_PARTS - 1);

  state_e                  state_q, state_d;
  logic [DEG_W:0]          k_q, k_d;
  logic [DEG_W:0]          step_deg_q, step_deg_d;
  logic [DEG_W:0]          degree_q, degree_d;
  logic [PART_WIDTH-1:0]   part_idx_q, part_idx_d;
  logic [PART_WIDTH-1:0]   best_part_q, best_part_d;
  logic [PART_WIDTH-1:0]   old_part_q, old_part_d;
  logic [PART_WIDTH-1:0]   cur_part_q, cur_part_d;
  logic [ACC_WIDTH-1:0]    total_acc_q, total_acc_d;
  logic [ACC_WIDTH-1:0]    total_weight_q, total_weight_d;
  logic                    changed_q, changed_d;
  logic                    done_q, done_d;
  logic [ACC_WIDTH-1:0]    score_q [NUM_PARTS];
  logic [ACC_WIDTH-1:0]    score_d [NUM_PARTS];

  logic [NODE_ID_WIDTH+WEIGHT_WIDTH-1:0] rd_edge;
  logic [NODE_ID_WIDTH-1:0]              rd_nbr;
  logic [WEIGHT_WIDTH-1:0]               rd_weight;

  primitive_graph_edge_ram #(
    .DEPTH (MAX_DEGREE),
    .AW    (DEG_W),
    .DW    (NODE_ID_WIDTH + WEIGHT_WIDTH)
  ) u_edge_ram (
    .clk     (clk),
    .wr_en   (edge_wr_en && node_enable && (state_q == ST_IDLE)),
    .wr_addr (edge_wr_idx),
    .wr_data ({edge_wr_nbr, edge_wr_weight}),
    .rd_addr (k_q[DEG_W-1:0]),
    .rd_data (rd_edge)
  );

  assign {rd_nbr, rd_weight} = rd_edge;

  // NOTE: every signal written below gets a default first, so no path leaves one
  // unassigned and no latch is inferred; blocking '=' is correct in combinational code.
  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    step_deg_d     = step_deg_q;
    degree_d       = degree_q;
    part_idx_d     = part_idx_q;
    best_part_d    = best_part_q;
    old_part_d     = old_part_q;
    cur_part_d     = cur_part_q;
    total_acc_d    = total_acc_q;
    total_weight_d = total_weight_q;
    changed_d      = changed_q;
    done_d         = 1'b0;
    score_d        = score_q;

    if (node_enable) begin
      case (state_q)
        ST_IDLE: begin
          if (degree_wr) begin
            degree_d = (degree_in > DEG_MAX) ? DEG_MAX : degree_in;
          end
          if (part_init) begin
            cur_part_d = part_init_val;
          end
          // The step snapshots the pre-write degree and partition.
          if (start) begin
            for (int p = 0; p < NUM_PARTS; p++) score_d[p] = '0;
            total_acc_d = '0;
            k_d         = '0;
            part_idx_d  = '0;
            step_deg_d  = degree_q;
            best_part_d = cur_part_q;
            old_part_d  = cur_part_q;
            state_d     = (degree_q == '0) ? ST_UPDATE : ST_SCAN_REQ;
          end
        end
        ST_SCAN_REQ: begin
          if (nbr_req_ready) state_d = ST_SCAN_WAIT;
        end
        ST_SCAN_WAIT: begin
          if (nbr_rsp_valid) begin
            score_d[nbr_rsp_part] = score_q[nbr_rsp_part] + ACC_WIDTH'(rd_weight);
            total_acc_d           = total_acc_q + ACC_WIDTH'(rd_weight);
            k_d                   = k_q + DEG_ONE;
            state_d               = ((k_q + DEG_ONE) == step_deg_q) ? ST_ARGMAX : ST_SCAN_REQ;
          end
        end
        ST_ARGMAX: begin
          if (score_q[part_idx_q] > score_q[best_part_q]) best_part_d = part_idx_q;
          part_idx_d = part_idx_q + PART_ONE;
          if (part_idx_q == PART_TOP) state_d = ST_UPDATE;
        end
        ST_UPDATE: begin
          cur_part_d     = best_part_q;
          changed_d      = (best_part_q != old_part_q);
          total_weight_d = total_acc_q;
          done_d         = 1'b1;
          state_d        = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      k_q            <= '0;
      step_deg_q     <= '0;
      degree_q       <= '0;
      part_idx_q     <= '0;
      best_part_q    <= '0;
      old_part_q     <= '0;
      cur_part_q     <= '0;
      total_acc_q    <= '0;
      total_weight_q <= '0;
      changed_q      <= 1'b0;
      done_q         <= 1'b0;
      for (int p = 0; p < NUM_PARTS; p++) score_q[p] <= '0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      step_deg_q     <= step_deg_d;
      degree_q       <= degree_d;
      part_idx_q     <= part_idx_d;
      best_part_q    <= best_part_d;
      old_part_q     <= old_part_d;
      cur_part_q     <= cur_part_d;
      total_acc_q    <= total_acc_d;
      total_weight_q <= total_weight_d;
      changed_q      <= changed_d;
      done_q         <= done_d;
      score_q        <= score_d;
    end
  end

  assign busy              = (state_q != ST_IDLE);
  assign done              = done_q;
  assign changed           = changed_q;
  assign nbr_req_valid     = (state_q == ST_SCAN_REQ);
  assign nbr_req_id        = rd_nbr;
  assign current_partition = cur_part_q;
  assign total_weight      = total_weight_q;
  assign node_degree       = degree_q;

endmodule
